bsg_manycore_cache_dma_to_wh: RTL and testbench

- Sits directly downstream of the manycore-link-to-cache adapter and its bsg_cache instance. It consumes the cache's DMA interface and the adapter's wh_dest_east_not_west_o.
- Turns DMA read and write requests into wormhole packets toward an east or west memory controller.
- Takes wormhole fill responses and returns the fill data to the cache.
- One cache per instance. Responses must arrive in request order.

---
 rtl/bsg_manycore_pkg.sv | 21 ++
 rtl/bsg_manycore_cache_dma_to_wh_rx.sv | 62 ++++++
 rtl/bsg_manycore_cache_dma_to_wh.sv | 138 +++++++++++++
 tb/tb_bsg_manycore_cache_dma_to_wh.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_pkg.sv
// rtl/bsg_manycore_pkg.sv - wormhole header macro and FSM state types for the cache DMA bridge
`ifndef BSG_MANYCORE_PKG_SV
`define BSG_MANYCORE_PKG_SV

`define DECLARE_BSG_MANYCORE_DMA_WH_HEADER_S(cord_w, len_w, cid_w) \
  typedef struct packed { \
    logic              write_not_read; \
    logic [cid_w-1:0]  src_cid; \
    logic [cord_w-1:0] src_cord; \
    logic [len_w-1:0]  len; \
    logic [cord_w-1:0] dest_cord; \
  } bsg_manycore_dma_wh_header_s

package bsg_manycore_pkg;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_ADDR, S_DATA} dma_wh_send_state_e;
  typedef enum logic {R_HDR, R_DATA} dma_wh_recv_state_e;

endpackage

`endif

// File: rtl/bsg_manycore_cache_dma_to_wh_rx.sv
// rtl/bsg_manycore_cache_dma_to_wh_rx.sv - strips fill headers and streams fill words to the cache
module bsg_manycore_cache_dma_to_wh_rx
  import bsg_manycore_pkg::*;
  #(parameter int data_width_p          = 32
  , parameter int block_size_in_words_p = 8
  )
  (input  logic                    clk_i
  , input  logic                    reset_i
  , input  logic [data_width_p-1:0] wh_data_i
  , input  logic                    wh_v_i
  , output logic                    wh_yumi_o
  , output logic [data_width_p-1:0] dma_data_o
  , output logic                    dma_data_v_o
  , input  logic                    dma_data_ready_i
  );

  localparam int cnt_width_lp = $clog2(block_size_in_words_p);
  localparam logic [cnt_width_lp-1:0] last_word_lp = cnt_width_lp'(block_size_in_words_p - 1);

  dma_wh_recv_state_e state_r, state_n;
  logic [cnt_width_lp-1:0] cnt_r, cnt_n;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= R_HDR;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  assign dma_data_o = wh_data_i;

  always_comb begin
    state_n      = state_r;
    cnt_n        = cnt_r;
    wh_yumi_o    = 1'b0;
    dma_data_v_o = 1'b0;
    case (state_r)
      R_HDR: begin
        // the header carries nothing the cache needs, so it is dropped on arrival
        wh_yumi_o = wh_v_i & ~reset_i;
        if (wh_yumi_o) state_n = R_DATA;
      end
      R_DATA: begin
        dma_data_v_o = wh_v_i;
        wh_yumi_o    = wh_v_i & dma_data_ready_i;
        if (wh_yumi_o) begin
          if (cnt_r == last_word_lp) begin
            cnt_n   = '0;
            state_n = R_HDR;
          end else begin
            cnt_n = cnt_r + cnt_width_lp'(1);
          end
        end
      end
      default: state_n = R_HDR;
    endcase
  end

endmodule

// File: rtl/bsg_manycore_cache_dma_to_wh.sv
// rtl/bsg_manycore_cache_dma_to_wh.sv - bridges one cache DMA port to east/west wormhole memory controllers
module bsg_manycore_cache_dma_to_wh
  import bsg_manycore_pkg::*;
  #(parameter int dma_addr_width_p      = 28
  , parameter int data_width_p          = 32
  , parameter int block_size_in_words_p = 8
  , parameter int wh_cord_width_p       = 7
  , parameter int wh_len_width_p        = 4
  , parameter int wh_cid_width_p        = 2
  )
  (input  logic                        clk_i
  , input  logic                        reset_i
  , input  logic [dma_addr_width_p:0]   dma_pkt_i
  , input  logic                        dma_pkt_v_i
  , output logic                        dma_pkt_yumi_o
  , output logic [data_width_p-1:0]     dma_data_o
  , output logic                        dma_data_v_o
  , input  logic                        dma_data_ready_i
  , input  logic [data_width_p-1:0]     dma_data_i
  , input  logic                        dma_data_v_i
  , output logic                        dma_data_yumi_o
  , input  logic                        wh_dest_east_not_west_i
  , input  logic [wh_cord_width_p-1:0]  my_cord_i
  , input  logic [wh_cid_width_p-1:0]   my_cid_i
  , input  logic [wh_cord_width_p-1:0]  dest_cord_east_i
  , input  logic [wh_cord_width_p-1:0]  dest_cord_west_i
  , output logic [data_width_p-1:0]     wh_data_o
  , output logic                        wh_v_o
  , input  logic                        wh_ready_i
  , input  logic [data_width_p-1:0]     wh_data_i
  , input  logic                        wh_v_i
  , output logic                        wh_yumi_o
  );

  localparam int cnt_width_lp    = $clog2(block_size_in_words_p);
  localparam int offset_width_lp = cnt_width_lp + $clog2(data_width_p / 8);
  localparam logic [cnt_width_lp-1:0] last_word_lp = cnt_width_lp'(block_size_in_words_p - 1);

  `DECLARE_BSG_MANYCORE_DMA_WH_HEADER_S(wh_cord_width_p, wh_len_width_p, wh_cid_width_p);
  localparam int header_width_lp = $bits(bsg_manycore_dma_wh_header_s);

  dma_wh_send_state_e state_r, state_n;
  logic [cnt_width_lp-1:0]     cnt_r, cnt_n;
  logic [dma_addr_width_p-1:0] addr_r, addr_aligned;
  logic                        write_not_read_r;
  logic [wh_cord_width_p-1:0]  dest_cord_r;

  bsg_manycore_dma_wh_header_s header;
  logic [data_width_p-1:0]     header_flit, addr_flit;

  always_comb begin
    header.dest_cord      = dest_cord_r;
    header.len            = write_not_read_r ? wh_len_width_p'(block_size_in_words_p + 1)
                                             : wh_len_width_p'(1);
    header.src_cord       = my_cord_i;
    header.src_cid        = my_cid_i;
    header.write_not_read = write_not_read_r;
    header_flit = '0;
    header_flit[header_width_lp-1:0] = header;
    // memory controllers always fetch whole blocks, so the offset is dropped
    addr_aligned = addr_r;
    addr_aligned[offset_width_lp-1:0] = '0;
    addr_flit = '0;
    addr_flit[dma_addr_width_p-1:0] = addr_aligned;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r          <= S_IDLE;
      cnt_r            <= '0;
      addr_r           <= '0;
      write_not_read_r <= 1'b0;
      dest_cord_r      <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      if (dma_pkt_yumi_o) begin
        addr_r           <= dma_pkt_i[dma_addr_width_p-1:0];
        write_not_read_r <= dma_pkt_i[dma_addr_width_p];
        dest_cord_r      <= wh_dest_east_not_west_i ? dest_cord_east_i : dest_cord_west_i;
      end
    end
  end

  always_comb begin
    state_n         = state_r;
    cnt_n           = cnt_r;
    dma_pkt_yumi_o  = 1'b0;
    dma_data_yumi_o = 1'b0;
    wh_v_o          = 1'b0;
    wh_data_o       = '0;
    case (state_r)
      S_IDLE: begin
        dma_pkt_yumi_o = dma_pkt_v_i & ~reset_i;
        if (dma_pkt_yumi_o) state_n = S_HDR;
      end
      S_HDR: begin
        wh_v_o    = 1'b1;
        wh_data_o = header_flit;
        if (wh_ready_i) state_n = S_ADDR;
      end
      S_ADDR: begin
        wh_v_o    = 1'b1;
        wh_data_o = addr_flit;
        if (wh_ready_i) state_n = write_not_read_r ? S_DATA : S_IDLE;
      end
      S_DATA: begin
        wh_v_o          = dma_data_v_i;
        wh_data_o       = dma_data_i;
        dma_data_yumi_o = dma_data_v_i & wh_ready_i;
        if (dma_data_yumi_o) begin
          if (cnt_r == last_word_lp) begin
            cnt_n   = '0;
            state_n = S_IDLE;
          end else begin
            cnt_n = cnt_r + cnt_width_lp'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  bsg_manycore_cache_dma_to_wh_rx
    #(.data_width_p(data_width_p)
    , .block_size_in_words_p(block_size_in_words_p)
    ) rx
    (.clk_i(clk_i)
    , .reset_i(reset_i)
    , .wh_data_i(wh_data_i)
    , .wh_v_i(wh_v_i)
    , .wh_yumi_o(wh_yumi_o)
    , .dma_data_o(dma_data_o)
    , .dma_data_v_o(dma_data_v_o)
    , .dma_data_ready_i(dma_data_ready_i)
    );

endmodule

// File: tb/tb_bsg_manycore_cache_dma_to_wh.sv
// tb/tb_bsg_manycore_cache_dma_to_wh.sv - self-checking bench for the cache DMA to wormhole bridge
module tb_bsg_manycore_cache_dma_to_wh;

  localparam int AW = 28, DW = 32, BW = 8, CW = 7, LW = 4, IW = 2;
  localparam logic [CW-1:0] MY_CORD = 7'h05, EAST = 7'h3F, WEST = 7'h11;
  localparam logic [IW-1:0] MY_CID = 2'd2;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [AW:0]   dma_pkt_i;
  logic          dma_pkt_v_i, dma_pkt_yumi_o;
  logic [DW-1:0] dma_data_o, dma_data_i, wh_data_o, wh_data_i;
  logic          dma_data_v_o, dma_data_ready_i, dma_data_v_i, dma_data_yumi_o;
  logic          wh_dest_east_not_west_i, wh_v_o, wh_ready_i, wh_v_i, wh_yumi_o;
  logic [CW-1:0] my_cord_i, dest_cord_east_i, dest_cord_west_i;
  logic [IW-1:0] my_cid_i;

  always #5 clk_i = ~clk_i;

  bsg_manycore_cache_dma_to_wh dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_ready_i(dma_data_ready_i),
    .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o),
    .wh_dest_east_not_west_i(wh_dest_east_not_west_i),
    .my_cord_i(my_cord_i), .my_cid_i(my_cid_i),
    .dest_cord_east_i(dest_cord_east_i), .dest_cord_west_i(dest_cord_west_i),
    .wh_data_o(wh_data_o), .wh_v_o(wh_v_o), .wh_ready_i(wh_ready_i),
    .wh_data_i(wh_data_i), .wh_v_i(wh_v_i), .wh_yumi_o(wh_yumi_o)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: header fields packed by arithmetic from the field order, LSB first
  function automatic logic [DW-1:0] hdr_f(input logic wnr, input logic east);
    longint v;
    v = east ? longint'(EAST) : longint'(WEST);
    v += longint'(wnr ? BW + 1 : 1) << CW;
    v += longint'(MY_CORD) << (CW + LW);
    v += longint'(MY_CID) << (2 * CW + LW);
    v += longint'(wnr) << (2 * CW + LW + IW);
    return DW'(v);
  endfunction

  function automatic logic [DW-1:0] addr_f(input logic [AW-1:0] a);
    longint bb;
    bb = BW * DW / 8;
    return DW'((longint'(a) / bb) * bb);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    logic          wnr;
    logic [AW-1:0] addr;
    logic          east;
    logic [DW-1:0] hdr;
    logic [DW-1:0] aflit;
  } vec_t;
  vec_t vecs[4];

  logic [AW:0]   req_q[$];
  logic          req_east_q[$];
  logic [DW-1:0] evict_q[$], plan_q[$], exp_q[$];
  logic [DW:0]   rx_q[$];

  task automatic add_req(input logic wnr, input logic [AW-1:0] a, input logic e);
    logic [DW-1:0] w;
    req_q.push_back({wnr, a});
    req_east_q.push_back(e);
    if (wnr) begin
      for (int k = 0; k < BW; k++) begin
        w = $urandom;
        evict_q.push_back(w);
        plan_q.push_back(w);
      end
    end
  endtask

  task automatic add_fill();
    rx_q.push_back({1'b1, DW'($urandom)});
    for (int k = 0; k < BW; k++) rx_q.push_back({1'b0, DW'($urandom)});
  endtask

  task automatic monitor();
    logic [AW:0]   r;
    logic          e;
    logic [DW:0]   f;
    if (dma_pkt_yumi_o) begin
      chk("pkt_yumi_needs_v", dma_pkt_v_i, 1);
      if (dma_pkt_v_i && req_q.size() != 0) begin
        r = req_q.pop_front();
        e = req_east_q.pop_front();
        exp_q.push_back(hdr_f(r[AW], e));
        exp_q.push_back(addr_f(r[AW-1:0]));
        if (r[AW]) for (int k = 0; k < BW; k++) exp_q.push_back(plan_q.pop_front());
      end
    end
    if (wh_v_o && wh_ready_i) begin
      chk("wh_flit_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("wh_flit", wh_data_o, exp_q.pop_front());
    end
    if (dma_data_yumi_o) begin
      chk("evict_yumi_legal", dma_data_v_i && wh_ready_i && evict_q.size() != 0, 1);
      if (evict_q.size() != 0) void'(evict_q.pop_front());
    end
    if (wh_yumi_o) begin
      chk("rx_yumi_needs_v", wh_v_i, 1);
      if (wh_v_i && rx_q.size() != 0) begin
        f = rx_q.pop_front();
        if (f[DW]) chk("rx_hdr_not_filled", dma_data_v_o && dma_data_ready_i, 0);
        else begin
          chk("fill_handshake", dma_data_v_o && dma_data_ready_i, 1);
          chk("fill_data", dma_data_o, f[DW-1:0]);
        end
      end
    end else if (dma_data_v_o && dma_data_ready_i) begin
      chk("fill_without_yumi", 0, 1);
    end
  endtask

  task automatic run_model(input bit rnd, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (req_q.size() == 0 && exp_q.size() == 0 && evict_q.size() == 0 && rx_q.size() == 0) break;
      dma_pkt_v_i = (req_q.size() != 0) && (!rnd || $urandom_range(3) != 0);
      dma_pkt_i = (req_q.size() != 0) ? req_q[0] : {1'b0, AW'($urandom)};
      wh_dest_east_not_west_i = (req_east_q.size() != 0) ? req_east_q[0] : 1'($urandom);
      wh_ready_i = rnd ? 1'($urandom_range(1)) : ~wh_ready_i;
      dma_data_v_i = (evict_q.size() != 0) && (!rnd || $urandom_range(3) != 0);
      dma_data_i = dma_data_v_i ? evict_q[0] : DW'($urandom);
      wh_v_i = (rx_q.size() != 0) && (!rnd || $urandom_range(3) != 0);
      wh_data_i = wh_v_i ? rx_q[0][DW-1:0] : DW'($urandom);
      dma_data_ready_i = !rnd || ($urandom_range(1) != 0);
      @(negedge clk_i);
      monitor();
      tick();
    end
    chk("drain_req", req_q.size(), 0);
    chk("drain_flits", exp_q.size(), 0);
    chk("drain_evict", evict_q.size(), 0);
    chk("drain_fill", rx_q.size(), 0);
    dma_pkt_v_i = 0; dma_data_v_i = 0; wh_v_i = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx, s3, s4;
    vecs[0] = '{1'b0, 28'h0000104, 1'b1, 32'h000828BF, 32'h00000100};
    vecs[1] = '{1'b0, 28'hFFFFFFF, 1'b0, 32'h00082891, 32'h0FFFFFE0};
    vecs[2] = '{1'b1, 28'h0ABCDE5, 1'b0, 32'h00182C91, 32'h00ABCDE0};
    vecs[3] = '{1'b1, 28'h000001F, 1'b1, 32'h00182CBF, 32'h00000000};

    reset_i = 1; my_cord_i = MY_CORD; my_cid_i = MY_CID;
    dest_cord_east_i = EAST; dest_cord_west_i = WEST;
    dma_pkt_i = '0; dma_pkt_v_i = 1; dma_data_i = '0; dma_data_v_i = 1;
    dma_data_ready_i = 1; wh_dest_east_not_west_i = 0; wh_ready_i = 1;
    wh_data_i = '0; wh_v_i = 1;
    repeat (2) tick();
    @(negedge clk_i);
    chk("rst_pkt_yumi", dma_pkt_yumi_o, 0);
    chk("rst_wh_v", wh_v_o, 0);
    chk("rst_wh_yumi", wh_yumi_o, 0);
    chk("rst_fill_v", dma_data_v_o, 0);
    chk("rst_evict_yumi", dma_data_yumi_o, 0);
    tick();
    reset_i = 0; dma_pkt_v_i = 0; wh_v_i = 0;
    tick();

    foreach (vecs[i]) begin
      dma_pkt_v_i = 1; dma_pkt_i = {vecs[i].wnr, vecs[i].addr};
      wh_dest_east_not_west_i = vecs[i].east; wh_ready_i = 1;
      dma_data_v_i = 1; dma_data_i = 32'hA0;
      @(negedge clk_i);
      chk("vec_pkt_yumi", dma_pkt_yumi_o, 1);
      chk("vec_idle_no_flit", wh_v_o, 0);
      tick();
      dma_pkt_v_i = 0;
      wh_dest_east_not_west_i = ~vecs[i].east;
      @(negedge clk_i);
      chk("vec_hdr_v", wh_v_o, 1);
      chk("vec_hdr", wh_data_o, vecs[i].hdr);
      tick();
      @(negedge clk_i);
      chk("vec_addr_v", wh_v_o, 1);
      chk("vec_addr", wh_data_o, vecs[i].aflit);
      tick();
      if (vecs[i].wnr) begin
        for (int k = 0; k < BW; k++) begin
          dma_data_i = 32'hA0 + k;
          @(negedge clk_i);
          chk("vec_data_v", wh_v_o, 1);
          chk("vec_data", wh_data_o, 32'hA0 + k);
          chk("vec_evict_yumi", dma_data_yumi_o, 1);
          tick();
        end
      end
      @(negedge clk_i);
      chk("vec_end_idle", wh_v_o, 0);
      chk("vec_end_no_yumi", dma_data_yumi_o, 0);
      tick();
    end

    dma_pkt_v_i = 1; dma_pkt_i = {1'b1, 28'h0000040}; wh_dest_east_not_west_i = 0;
    dma_data_v_i = 1; dma_data_i = 32'hB0;
    tick();
    dma_pkt_v_i = 0;
    repeat (4) tick();
    @(negedge clk_i);
    chk("pre_rst_data_v", wh_v_o, 1);
    reset_i = 1; dma_pkt_v_i = 1;
    #1;
    chk("async_rst_wh_v", wh_v_o, 0);
    chk("async_rst_evict_yumi", dma_data_yumi_o, 0);
    chk("async_rst_pkt_yumi", dma_pkt_yumi_o, 0);
    tick(); tick();
    reset_i = 0; dma_pkt_i = {1'b0, 28'h0000104}; wh_dest_east_not_west_i = 1;
    @(negedge clk_i);
    chk("post_rst_yumi", dma_pkt_yumi_o, 1);
    tick();
    dma_pkt_v_i = 0;
    @(negedge clk_i);
    chk("post_rst_hdr", wh_data_o, 32'h000828BF);
    tick();
    @(negedge clk_i);
    chk("post_rst_addr", wh_data_o, 32'h00000100);
    tick();
    @(negedge clk_i);
    chk("post_rst_idle", wh_v_o, 0);
    tick();
    dma_data_v_i = 0;

    wh_v_i = 1; wh_data_i = 32'hEE; dma_data_ready_i = 1;
    @(negedge clk_i);
    chk("fill_hdr_yumi", wh_yumi_o, 1);
    chk("fill_hdr_no_v", dma_data_v_o, 0);
    tick();
    idx = 0; s3 = 0; s4 = 0;
    for (int c = 0; c < 40 && idx < BW; c++) begin
      wh_data_i = 32'hD0 + idx;
      dma_data_ready_i = !((idx == 3 && s3 < 2) || (idx == 4 && s4 < 1));
      @(negedge clk_i);
      chk("fill_v", dma_data_v_o, 1);
      chk("fill_word", dma_data_o, 32'hD0 + idx);
      chk("fill_yumi", wh_yumi_o, dma_data_ready_i);
      if (!dma_data_ready_i) begin
        if (idx == 3) s3++; else s4++;
      end else idx++;
      tick();
    end
    chk("fill_done", idx, BW);
    wh_data_i = 32'hEF;
    @(negedge clk_i);
    chk("fill_next_hdr_yumi", wh_yumi_o, 1);
    chk("fill_next_hdr_no_v", dma_data_v_o, 0);
    wh_v_i = 0;
    tick();

    add_req(1'b1, AW'($urandom), 1'b1);
    add_req(1'b1, AW'($urandom), 1'b0);
    add_req(1'b0, AW'($urandom), 1'b1);
    add_fill();
    run_model(1'b0, 300);

    for (int n = 0; n < 30; n++) add_req(1'($urandom), AW'($urandom), 1'($urandom));
    for (int n = 0; n < 15; n++) add_fill();
    run_model(1'b1, 8000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
